spram_ctrl: RTL and testbench
=============================

# spram_ctrl

Command front-end for the single-port RAM (`spram`) that owns the RAM's `we`/`re`/`addr` pins and its bidirectional `data` bus. Upstream logic issues read/write commands over a valid/ready handshake. The controller sequences the RAM strobes, drives or releases the tri-state bus, captures read data, and returns it over a valid/ready response channel. It sits directly upstream of `spram` and is the only driver of the RAM bus besides the RAM itself.

## Interface
Parameters:
- `ADDR_W`, 4, RAM address width (16 words).
- `DATA_W`, 8, RAM word width.
- `RD_LAT`, 1, cycles `ram_re` is held before read data is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response beat present.
- `rsp_ready`  in  1  upstream accepts response.
- `rsp_rdata`  out  DATA_W  read data (or echoed write data, see Configuration).
- `ram_we`  out  1  to `spram.we`.
- `ram_re`  out  1  to `spram.re`.
- `ram_addr`  out  ADDR_W  to `spram.addr`.
- `ram_data`  inout  DATA_W  to `spram.data`; driven only while writing, else `'z`.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, register `cmd_addr`, `cmd_wdata`, `cmd_we`. Next state is WRITE if `cmd_we`=1, else READ with wait counter loaded to `RD_LAT-1`.
- WRITE (1 cycle): `ram_we`=1, `ram_re`=0, `ram_addr`=latched addr, `ram_data` driven with latched data. Next state is IDLE, or RESP when `SPRAM_CTRL_WRRESP_EN` is defined.
- READ: `ram_re`=1, `ram_we`=0, `ram_addr`=latched addr, bus released. Counter decrements each cycle. On the cycle the counter reads 0, `ram_data` is captured into `rsp_rdata` at the clock edge and the next state is RESP.
- RESP: `rsp_valid`=1 and `rsp_rdata` is held stable until `rsp_ready`=1. Next state is IDLE.
- `cmd_ready`=0 in every state except IDLE. Commands are never queued.
- `ram_we` and `ram_re` are never both 1. The bus driver enable is exactly `ram_we && !ram_re`.
- `ram_addr` holds its last value in IDLE and RESP.
- Address is used unmodified; no wrap or range check is needed (full ADDR_W space).

## Timing
- Reset values (async assert, sync effect on release): state=IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `ram_we`=0, `ram_re`=0, `ram_addr`=0, bus `'z`.
- Reset asserted mid-WRITE or mid-READ: strobes drop and the bus releases immediately, without waiting for a clock. The in-flight command is discarded and no response is produced.
- Write: accept at edge N, `ram_we` high for cycle N+1, `cmd_ready` high again in cycle N+2. Throughput is 1 write per 2 cycles.
- Read: accept at edge N, `ram_re` high for cycles N+1..N+RD_LAT, `rsp_valid` high from cycle N+RD_LAT+1. With `rsp_ready` tied high, this gives a 1-cycle response beat and a minimum read period of RD_LAT+2 cycles.
- `rsp_ready` held low: RESP persists indefinitely, `cmd_ready` stays 0, and RAM strobes stay 0.
- A `cmd_valid` deasserted before acceptance has no effect. Command fields are sampled only on the accept edge.

## Configuration
- `SPRAM_CTRL_WRRESP_EN` defined: WRITE goes to RESP. The write produces one response beat with `rsp_rdata` equal to the written data, so upstream can count completions.
- `SPRAM_CTRL_WRRESP_EN` not defined: writes complete silently with no response beat. `rsp_valid` only ever asserts for reads.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. All outputs match the reset values and `ram_data` reads `'z`.
- Fill/readback: write data=i to addr=i for i=0..15, then read addr 0..15 with `rsp_ready`=1. `rsp_rdata` returns 0x00..0x0F in order, `ram_we` and `ram_re` are never high together, and the bus is driven only during WRITE cycles.
- Backpressure: read addr 5 (holding 0xA5) with `rsp_ready`=0 for 4 cycles. `rsp_valid`=1 with 0xA5 stays stable and `cmd_ready`=0 throughout; after `rsp_ready`=1, one beat is delivered and `cmd_ready`=1 on the next cycle.
- Latency: with RD_LAT=3, `ram_re` is high for exactly 3 cycles and `rsp_valid` rises 4 cycles after the accept edge.
- Reset mid-read: assert `rst_n`=0 while `ram_re`=1. `ram_re` drops without waiting for a clock edge, no `rsp_valid` follows reset release, and the next command completes normally.
- Macro: write 0x3C to addr 2. With `SPRAM_CTRL_WRRESP_EN`, one beat with `rsp_rdata`=0x3C is produced; without it, `rsp_valid` stays 0.

Source files
------------

// File: rtl/spram_ctrl.sv
// Command front-end for the single-port RAM: sequences we/re strobes, owns the tri-state data bus,
// and returns read data over a valid/ready response channel. Define SPRAM_CTRL_WRRESP_EN for write responses.
module spram_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              ram_we,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready high
   // WRITE | one cycle of ram_we with the bus driven
   // READ  | ram_re held while the wait counter runs down
   // RESP  | response beat held until rsp_ready
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(RD_LAT - 1);

   if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("spram_ctrl: RD_LAT must be in 1..15");
   end

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              drv_en;

   // Strobes decode straight from state so an async reset drops them without a clock.
   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign ram_we    = (state == WRITE);
   assign ram_re    = (state == READ);
   assign ram_addr  = addr_q;
   assign rsp_rdata = rdata_q;
   assign drv_en    = ram_we && !ram_re;
   assign ram_data  = drv_en ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  if (cmd_we) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                     cnt   <= RD_LAT_M1;
                  end
               end
            end
            WRITE: begin
`ifdef SPRAM_CTRL_WRRESP_EN
               rdata_q <= wdata_q;
               state   <= RESP;
`else
               state   <= IDLE;
`endif
            end
            READ: begin
               if (cnt == '0) begin
                  rdata_q <= ram_data;
                  state   <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spram_ctrl.sv
// Scoreboard bench for spram_ctrl with a behavioural single-port RAM on the tri-state bus.
module tb_spram_ctrl;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 3;

   logic              clk = 0;
   logic              rst_n = 0;
   logic              cmd_valid = 0;
   logic              cmd_ready;
   logic              cmd_we = 0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1;
   logic [DATA_W-1:0] rsp_rdata;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   wire  [DATA_W-1:0] ram_data;

   logic [DATA_W-1:0] mem [16];
   logic [DATA_W-1:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   spram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   // RAM model: combinational read while re, write on the clock edge.
   assign ram_data = ram_re ? mem[ram_addr] : {DATA_W{1'bz}};
   always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted response beat and watches bus rules.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("we_re_exclusive", {31'd0, ram_we & ram_re}, 0);
         if (!ram_we && !ram_re) chk("bus_released", {31'd0, ram_data === {DATA_W{1'bz}}}, 1);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", {24'd0, rsp_rdata}, 32'hFFFF_FFFF);
            end else begin
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // Called at posedge+1; returns at accept edge+1.
   task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic expect_rsp);
      int budget = 100;
      while (!cmd_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) chk("cmd_ready_timeout", 0, 1);
      cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      if (expect_rsp) exp_q.push_back(we ? d : mem[a]);
      @(posedge clk); #1;
      cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
   endtask

`ifdef SPRAM_CTRL_WRRESP_EN
   localparam logic WR_RSP = 1'b1;
`else
   localparam logic WR_RSP = 1'b0;
`endif

   initial begin
      int budget;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
      chk("rst_ram_we", {31'd0, ram_we}, 0);
      chk("rst_ram_re", {31'd0, ram_re}, 0);
      chk("rst_ram_addr", {28'd0, ram_addr}, 0);
      chk("rst_bus_z", {31'd0, ram_data === {DATA_W{1'bz}}}, 1);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // Fill / readback
      for (int i = 0; i < 16; i++) issue(1'b1, ADDR_W'(i), DATA_W'(i), WR_RSP);
      for (int i = 0; i < 16; i++) issue(1'b0, ADDR_W'(i), 'x, 1'b1);

      // Latency: re for exactly RD_LAT cycles, valid RD_LAT+1 cycles after accept
      issue(1'b0, 4'd11, 'x, 1'b1);
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         @(negedge clk);
         chk($sformatf("lat_re_c%0d", k), {31'd0, ram_re}, (k <= RD_LAT) ? 1 : 0);
         chk($sformatf("lat_valid_c%0d", k), {31'd0, rsp_valid}, (k == RD_LAT + 1) ? 1 : 0);
      end
      @(posedge clk); #1;

      // Backpressure on a read of addr 5 holding 0xA5
      issue(1'b1, 4'd5, 8'hA5, WR_RSP);
      rsp_ready = 0;
      issue(1'b0, 4'd5, 'x, 1'b1);
      budget = 20;
      @(negedge clk);
      while (!rsp_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk("bp_valid_timeout", 0, 1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid}, 1);
         chk("bp_rdata", {24'd0, rsp_rdata}, 32'hA5);
         chk("bp_cmd_ready", {31'd0, cmd_ready}, 0);
         chk("bp_strobes", {30'd0, ram_we, ram_re}, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_after_ready", {31'd0, cmd_ready}, 1);
      chk("bp_after_valid", {31'd0, rsp_valid}, 0);
      @(posedge clk); #1;

      // Reset mid-read
      issue(1'b0, 4'd9, 'x, 1'b0);
      @(negedge clk);
      chk("mid_rd_re_before", {31'd0, ram_re}, 1);
      #2 rst_n = 0;
      #1;
      chk("mid_rd_re_async", {31'd0, ram_re}, 0);
      chk("mid_rd_bus_z", {31'd0, ram_data === {DATA_W{1'bz}}}, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_no_valid", {31'd0, rsp_valid}, 0);
      end
      @(posedge clk); #1;
      issue(1'b0, 4'd7, 'x, 1'b1);

      // Write-response option
      issue(1'b1, 4'd2, 8'h3C, WR_RSP);
`ifndef SPRAM_CTRL_WRRESP_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("wr_no_rsp", {31'd0, rsp_valid}, 0);
      end
      @(posedge clk); #1;
`endif
      issue(1'b0, 4'd2, 'x, 1'b1);

      budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
